// File: rtl/hs32_bus_arb.sv
// Two-master (Caravel Wishbone host / hs32 CPU) arbiter for the shared stb/ack bus,
// with one-outstanding-transaction sequencing and a timeout watchdog.
module hs32_bus_arb #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF,
   parameter bit          FAIR     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_hold,
   input  logic        wb_stb,
   input  logic        wb_rw,
   input  logic [31:0] wb_addr,
   input  logic [31:0] wb_dtw,
   output logic        wb_ack,
   output logic [31:0] wb_dtr,
   input  logic        cpu_stb,
   input  logic        cpu_rw,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_dtw,
   output logic        cpu_ack,
   output logic [31:0] cpu_dtr,
   output logic        o_stb,
   output logic        o_rw,
   output logic [31:0] o_addr,
   output logic [31:0] o_dtw,
   input  logic        i_ack,
   input  logic [31:0] i_dtr,
   output logic        o_owner,
   output logic        o_timeout,
   input  logic        i_clr_timeout
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   logic [1:0]    state;
   logic          pend_valid;
   logic          pend_rw;
   logic [31:0]   pend_addr;
   logic [31:0]   pend_dtw;
   logic          last_owner;
   logic [CW-1:0] cnt;
   logic [31:0]   rdata;

   logic cpu_req;
   logic cpu_ok;
   logic grant;
   logic win_wb;
   logic cpu_win;
   logic cpu_busy;
   logic capture;
   logic timeout_evt;

   assign cpu_req = pend_valid | cpu_stb;
   assign cpu_ok  = cpu_req & ~i_hold;

   always_comb begin
      grant  = 1'b0;
      win_wb = 1'b0;
      if (state == ST_IDLE) begin
         if (cpu_ok && wb_stb) begin
            grant  = 1'b1;
            win_wb = FAIR ? ~last_owner : 1'b0;
         end else if (cpu_ok) begin
            grant  = 1'b1;
         end else if (wb_stb) begin
            grant  = 1'b1;
            win_wb = 1'b1;
         end
      end
   end

   assign cpu_win  = grant & ~win_wb;
   assign cpu_busy = (state != ST_IDLE) & ~o_owner;
   // An IDLE pulse that wins immediately is consumed directly and never lands in the slot.
   assign capture  = cpu_stb & ~pend_valid & ~cpu_busy & ~cpu_win;

   assign timeout_evt = (state == ST_WAIT) && !i_ack && (cnt == CW'(TIMEOUT));

   assign o_stb   = (state == ST_ISSUE);
   assign wb_ack  = (state == ST_RESP) &  o_owner;
   assign cpu_ack = (state == ST_RESP) & ~o_owner;
   assign wb_dtr  = rdata;
   assign cpu_dtr = rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_valid <= 1'b0;
         pend_rw    <= 1'b0;
         pend_addr  <= '0;
         pend_dtw   <= '0;
      end else if (capture) begin
         pend_valid <= 1'b1;
         pend_rw    <= cpu_rw;
         pend_addr  <= cpu_addr;
         pend_dtw   <= cpu_dtw;
      end else if (cpu_win) begin
         pend_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_timeout <= 1'b0;
      end else if (timeout_evt) begin
         o_timeout <= 1'b1;
      end else if (i_clr_timeout) begin
         o_timeout <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_owner <= 1'b1;
         o_owner    <= 1'b0;
         o_rw       <= 1'b0;
         o_addr     <= '0;
         o_dtw      <= '0;
         cnt        <= '0;
         rdata      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  state      <= ST_ISSUE;
                  cnt        <= '0;
                  o_owner    <= win_wb;
                  last_owner <= win_wb;
                  if (win_wb) begin
                     o_rw   <= wb_rw;
                     o_addr <= wb_addr;
                     o_dtw  <= wb_dtw;
                  end else if (pend_valid) begin
                     o_rw   <= pend_rw;
                     o_addr <= pend_addr;
                     o_dtw  <= pend_dtw;
                  end else begin
                     o_rw   <= cpu_rw;
                     o_addr <= cpu_addr;
                     o_dtw  <= cpu_dtw;
                  end
               end
            end
            ST_ISSUE: begin
               if (i_ack) begin
                  rdata <= i_dtr;
                  state <= ST_RESP;
               end else begin
                  cnt   <= cnt + CW'(1);
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_ack) begin
                  rdata <= i_dtr;
                  state <= ST_RESP;
               end else if (timeout_evt) begin
                  rdata <= ERR_DATA;
                  state <= ST_RESP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hs32_bus_arb.sv
// Directed bench for hs32_bus_arb: round-robin unit plus a fixed-priority unit on shared stimulus.
module tb_hs32_bus_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_hold;
   logic        wb_stb, wb_rw;
   logic [31:0] wb_addr, wb_dtw;
   logic        cpu_stb, cpu_rw;
   logic [31:0] cpu_addr, cpu_dtw;
   logic        i_ack;
   logic [31:0] i_dtr;
   logic        i_clr_timeout;

   logic        wb_ack, cpu_ack, o_stb, o_rw, o_owner, o_timeout;
   logic [31:0] wb_dtr, cpu_dtr, o_addr, o_dtw;

   logic        fp_wb_ack, fp_cpu_ack, fp_o_stb, fp_o_rw, fp_o_owner, fp_o_timeout;
   logic [31:0] fp_wb_dtr, fp_cpu_dtr, fp_o_addr, fp_o_dtw;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hs32_bus_arb #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF), .FAIR(1'b1)) dut (
      .clk(clk), .rst(rst), .i_hold(i_hold),
      .wb_stb(wb_stb), .wb_rw(wb_rw), .wb_addr(wb_addr), .wb_dtw(wb_dtw),
      .wb_ack(wb_ack), .wb_dtr(wb_dtr),
      .cpu_stb(cpu_stb), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_dtw(cpu_dtw),
      .cpu_ack(cpu_ack), .cpu_dtr(cpu_dtr),
      .o_stb(o_stb), .o_rw(o_rw), .o_addr(o_addr), .o_dtw(o_dtw),
      .i_ack(i_ack), .i_dtr(i_dtr), .o_owner(o_owner),
      .o_timeout(o_timeout), .i_clr_timeout(i_clr_timeout)
   );

   hs32_bus_arb #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF), .FAIR(1'b0)) dut_fp (
      .clk(clk), .rst(rst), .i_hold(i_hold),
      .wb_stb(wb_stb), .wb_rw(wb_rw), .wb_addr(wb_addr), .wb_dtw(wb_dtw),
      .wb_ack(fp_wb_ack), .wb_dtr(fp_wb_dtr),
      .cpu_stb(cpu_stb), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_dtw(cpu_dtw),
      .cpu_ack(fp_cpu_ack), .cpu_dtr(fp_cpu_dtr),
      .o_stb(fp_o_stb), .o_rw(fp_o_rw), .o_addr(fp_o_addr), .o_dtw(fp_o_dtw),
      .i_ack(i_ack), .i_dtr(i_dtr), .o_owner(fp_o_owner),
      .o_timeout(fp_o_timeout), .i_clr_timeout(i_clr_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".o_stb"},     32'(o_stb),     32'd0);
      chk({tag, ".o_rw"},      32'(o_rw),      32'd0);
      chk({tag, ".o_addr"},    o_addr,         32'd0);
      chk({tag, ".o_dtw"},     o_dtw,          32'd0);
      chk({tag, ".o_owner"},   32'(o_owner),   32'd0);
      chk({tag, ".o_timeout"}, 32'(o_timeout), 32'd0);
      chk({tag, ".wb_ack"},    32'(wb_ack),    32'd0);
      chk({tag, ".cpu_ack"},   32'(cpu_ack),   32'd0);
      chk({tag, ".wb_dtr"},    wb_dtr,         32'd0);
      chk({tag, ".cpu_dtr"},   cpu_dtr,        32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1; i_hold = 1'b0; i_clr_timeout = 1'b0;
      wb_stb = 1'b0; wb_rw = 1'b0; wb_addr = '0; wb_dtw = '0;
      cpu_stb = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_dtw = '0;
      i_ack = 1'b0; i_dtr = '0;
      #2;
      chk_zero("reset");
      step(); step();
      rst = 1'b0;

      // 1: lone CPU read, device acks two cycles after the strobe
      cpu_stb = 1'b1; cpu_addr = 32'h100;
      step();
      cpu_stb = 1'b0;
      chk("t1.o_stb",   32'(o_stb),   32'd1);
      chk("t1.o_addr",  o_addr,       32'h100);
      chk("t1.o_owner", 32'(o_owner), 32'd0);
      step();
      chk("t1.wait_stb", 32'(o_stb), 32'd0);
      step();
      i_ack = 1'b1; i_dtr = 32'h12345678;
      chk("t1.early_ack", 32'(cpu_ack), 32'd0);
      step();
      i_ack = 1'b0;
      chk("t1.cpu_ack", 32'(cpu_ack), 32'd1);
      chk("t1.cpu_dtr", cpu_dtr,      32'h12345678);
      chk("t1.wb_ack",  32'(wb_ack),  32'd0);
      step();
      chk("t1.ack_len", 32'(cpu_ack), 32'd0);

      // 2: simultaneous requests; device acks in ISSUE throughout
      rst = 1'b1; step(); rst = 1'b0;
      i_ack = 1'b1; i_dtr = 32'hA5A50001;
      wb_stb = 1'b1; wb_addr = 32'h200; cpu_stb = 1'b1; cpu_addr = 32'h300;
      step();
      cpu_stb = 1'b0;
      chk("t2.first_owner",    32'(o_owner),    32'd0);
      chk("t2.first_addr",     o_addr,          32'h300);
      chk("t2.fp_first_owner", 32'(fp_o_owner), 32'd0);
      step();
      chk("t2.cpu_ack", 32'(cpu_ack), 32'd1);
      step();
      chk("t2.idle_stb", 32'(o_stb), 32'd0);
      step();
      chk("t2.second_owner", 32'(o_owner), 32'd1);
      chk("t2.second_addr",  o_addr,       32'h200);
      step();
      chk("t2.wb_ack", 32'(wb_ack), 32'd1);
      chk("t2.wb_dtr", wb_dtr,      32'hA5A50001);
      wb_stb = 1'b0;
      step();
      cpu_stb = 1'b1; cpu_addr = 32'h304;
      step();
      cpu_stb = 1'b0;
      chk("t2.solo_addr", o_addr, 32'h304);
      step();
      step();
      wb_stb = 1'b1; wb_addr = 32'h204; cpu_stb = 1'b1; cpu_addr = 32'h308;
      step();
      cpu_stb = 1'b0;
      chk("t2.rr_owner",    32'(o_owner),    32'd1);
      chk("t2.rr_addr",     o_addr,          32'h204);
      chk("t2.fp_owner",    32'(fp_o_owner), 32'd0);
      chk("t2.fp_addr",     fp_o_addr,       32'h308);
      step();
      chk("t2.rr_wb_ack",   32'(wb_ack),     32'd1);
      chk("t2.fp_cpu_ack",  32'(fp_cpu_ack), 32'd1);
      step();
      step();
      chk("t2.rr_owner2",   32'(o_owner),    32'd0);
      chk("t2.rr_addr2",    o_addr,          32'h308);
      chk("t2.fp_owner2",   32'(fp_o_owner), 32'd1);
      step();
      chk("t2.rr_cpu_ack",  32'(cpu_ack),    32'd1);
      chk("t2.fp_wb_ack",   32'(fp_wb_ack),  32'd1);
      wb_stb = 1'b0;
      step();
      i_ack = 1'b0;

      // 3: CPU frozen while Wishbone writes
      i_hold = 1'b1; cpu_stb = 1'b1; cpu_addr = 32'h40;
      step();
      cpu_stb = 1'b0;
      chk("t3.held_stb", 32'(o_stb), 32'd0);
      wb_stb = 1'b1; wb_rw = 1'b1; wb_addr = 32'h8; wb_dtw = 32'hAA;
      step();
      chk("t3.wb_owner", 32'(o_owner), 32'd1);
      chk("t3.wb_addr",  o_addr,       32'h8);
      chk("t3.wb_rw",    32'(o_rw),    32'd1);
      chk("t3.wb_dtw",   o_dtw,        32'hAA);
      i_ack = 1'b1; i_dtr = 32'h0;
      step();
      i_ack = 1'b0;
      chk("t3.wb_ack",  32'(wb_ack),  32'd1);
      chk("t3.cpu_ack", 32'(cpu_ack), 32'd0);
      wb_stb = 1'b0; wb_rw = 1'b0;
      step();
      step();
      chk("t3.still_held", 32'(o_stb), 32'd0);
      i_hold = 1'b0;
      step();
      chk("t3.cpu_stb",   32'(o_stb),   32'd1);
      chk("t3.cpu_owner", 32'(o_owner), 32'd0);
      chk("t3.cpu_addr",  o_addr,       32'h40);
      i_ack = 1'b1; i_dtr = 32'h0;
      step();
      i_ack = 1'b0;
      chk("t3.cpu_ack2", 32'(cpu_ack), 32'd1);
      step();

      // 4: silent device, TIMEOUT=4
      cpu_stb = 1'b1; cpu_addr = 32'h500;
      step();
      cpu_stb = 1'b0;
      chk("t4.o_stb", 32'(o_stb), 32'd1);
      step(); step(); step(); step();
      chk("t4.no_early_ack", 32'(cpu_ack), 32'd0);
      step();
      chk("t4.cpu_ack",   32'(cpu_ack),   32'd1);
      chk("t4.err_data",  cpu_dtr,        32'hDEADBEEF);
      chk("t4.timeout",   32'(o_timeout), 32'd1);
      step();
      chk("t4.sticky", 32'(o_timeout), 32'd1);
      i_clr_timeout = 1'b1;
      step();
      i_clr_timeout = 1'b0;
      chk("t4.cleared", 32'(o_timeout), 32'd0);

      // 5: ack in the ISSUE cycle, then constant-high ack while idle
      wb_stb = 1'b1; wb_addr = 32'h600;
      step();
      chk("t5.o_stb", 32'(o_stb), 32'd1);
      i_ack = 1'b1; i_dtr = 32'hCAFEF00D;
      step();
      chk("t5.wb_ack", 32'(wb_ack), 32'd1);
      chk("t5.wb_dtr", wb_dtr,      32'hCAFEF00D);
      wb_stb = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5.idle_wb_ack",  32'(wb_ack),  32'd0);
         chk("t5.idle_cpu_ack", 32'(cpu_ack), 32'd0);
         chk("t5.idle_stb",     32'(o_stb),   32'd0);
      end
      chk("t5.addr_hold", o_addr, 32'h600);
      i_ack = 1'b0;

      // 6: reset while waiting, with a CPU request parked in the pending slot
      i_hold = 1'b1; cpu_stb = 1'b1; cpu_rw = 1'b1; cpu_addr = 32'h700; cpu_dtw = 32'h55;
      wb_stb = 1'b1; wb_addr = 32'h800;
      step();
      cpu_stb = 1'b0; i_hold = 1'b0;
      chk("t6.wb_owner", 32'(o_owner), 32'd1);
      chk("t6.wb_addr",  o_addr,       32'h800);
      step();
      rst = 1'b1;
      #1;
      chk_zero("t6.async");
      wb_stb = 1'b0;
      step(); step();
      rst = 1'b0;
      i_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6.no_stb",     32'(o_stb),   32'd0);
         chk("t6.no_cpu_ack", 32'(cpu_ack), 32'd0);
         chk("t6.no_wb_ack",  32'(wb_ack),  32'd0);
      end
      i_ack = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
